// File: rtl/bubble_sort_engine.sv
`default_nettype none
// bubble_sort_engine: in-place bubble sort over an external sync-read RAM, then streams the result.
// Rev 1.0
module bubble_sort_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int SWAP_W = 16
) (
  input  logic              c_clk,
  input  logic              c_rst,
  input  logic              c_go,
  input  logic              c_desc,
  output logic              c_busy,
  output logic              c_done,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_re,
  output logic              c_we,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              c_out_valid,
  output logic [DATA_W-1:0] c_out_data,
  input  logic              c_out_ready,
  output logic [SWAP_W-1:0] c_swaps
);

  localparam int LAST_PASS = (DEPTH >= 2) ? DEPTH - 2 : 0;
  localparam logic [ADDR_W-1:0] c_last_pass = ADDR_W'(LAST_PASS);
  localparam logic [ADDR_W-1:0] c_last_out  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [SWAP_W-1:0] c_swap_one  = SWAP_W'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PASS_INIT = 4'd1,
    S_RD_A      = 4'd2,
    S_RD_B      = 4'd3,
    S_LATCH     = 4'd4,
    S_CMP       = 4'd5,
    S_WR_A      = 4'd6,
    S_WR_B      = 4'd7,
    S_NEXT      = 4'd8,
    S_PASS_END  = 4'd9,
    S_OUT_RD    = 4'd10,
    S_OUT_WAIT  = 4'd11,
    S_OUT_HOLD  = 4'd12,
    S_DONE      = 4'd13
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pass_q, pass_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic [DATA_W-1:0] t1_q, t1_d, t2_q, t2_d;
  logic              swapped_q, swapped_d;
  logic              desc_q, desc_d;
  logic [SWAP_W-1:0] swaps_q, swaps_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              w_swap;

  // Strict compare keeps equal elements in place, so the sort is stable.
  assign w_swap = desc_q ? (t1_q < t2_q) : (t1_q > t2_q);

  assign c_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign c_out_valid = valid_q;
  assign c_out_data  = odata_q;
  assign c_swaps     = swaps_q;

  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q   <= S_IDLE;
      pass_q    <= '0;
      idx_q     <= '0;
      oidx_q    <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      swapped_q <= 1'b0;
      desc_q    <= 1'b0;
      swaps_q   <= '0;
      valid_q   <= 1'b0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      idx_q     <= idx_d;
      oidx_q    <= oidx_d;
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      swapped_q <= swapped_d;
      desc_q    <= desc_d;
      swaps_q   <= swaps_d;
      valid_q   <= valid_d;
      odata_q   <= odata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    oidx_d    = oidx_q;
    t1_d      = t1_q;
    t2_d      = t2_q;
    swapped_d = swapped_q;
    desc_d    = desc_q;
    swaps_d   = swaps_q;
    valid_d   = valid_q;
    odata_d   = odata_q;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    c_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (c_go) begin
          desc_d  = c_desc;
          pass_d  = '0;
          swaps_d = '0;
          oidx_d  = '0;
          state_d = (DEPTH == 1) ? S_OUT_RD : S_PASS_INIT;
        end
      end
      S_PASS_INIT: begin
        idx_d     = '0;
        swapped_d = 1'b0;
        state_d   = S_RD_A;
      end
      S_RD_A: begin
        c_re    = 1'b1;
        c_addr  = idx_q;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        c_re    = 1'b1;
        c_addr  = idx_q + c_addr_one;
        t1_d    = c_rdata;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        t2_d    = c_rdata;
        state_d = S_CMP;
      end
      S_CMP: begin
        state_d = w_swap ? S_WR_A : S_NEXT;
      end
      S_WR_A: begin
        c_we    = 1'b1;
        c_addr  = idx_q;
        c_wdata = t2_q;
        state_d = S_WR_B;
      end
      S_WR_B: begin
        c_we      = 1'b1;
        c_addr    = idx_q + c_addr_one;
        c_wdata   = t1_q;
        swapped_d = 1'b1;
        if (swaps_q != '1) swaps_d = swaps_q + c_swap_one;
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == (c_last_pass - pass_q)) begin
          state_d = S_PASS_END;
        end else begin
          idx_d   = idx_q + c_addr_one;
          state_d = S_RD_A;
        end
      end
      S_PASS_END: begin
        // A pass with no swaps proves the array is already ordered.
        if (!swapped_q || (pass_q == c_last_pass)) begin
          oidx_d  = '0;
          state_d = S_OUT_RD;
        end else begin
          pass_d  = pass_q + c_addr_one;
          state_d = S_PASS_INIT;
        end
      end
      S_OUT_RD: begin
        c_re    = 1'b1;
        c_addr  = oidx_q;
        state_d = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        odata_d = c_rdata;
        valid_d = 1'b1;
        state_d = S_OUT_HOLD;
      end
      S_OUT_HOLD: begin
        if (c_out_ready) begin
          valid_d = 1'b0;
          if (oidx_q == c_last_out) begin
            state_d = S_DONE;
          end else begin
            oidx_d  = oidx_q + c_addr_one;
            state_d = S_OUT_RD;
          end
        end
      end
      S_DONE: begin
        c_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_engine.sv
`default_nettype none
// tb_bubble_sort_engine: directed self-checking bench for bubble_sort_engine with a sync-read RAM model.
// Rev 1.0
module tb_bubble_sort_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int SWAP_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic              desc = 1'b0;
  logic              ready = 1'b1;
  logic              busy, done, re, we, out_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, out_data;
  logic [DATA_W-1:0] rdata = '0;
  logic [SWAP_W-1:0] swaps;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              load_req = 1'b0;
  logic [63:0]       load_vec = '0;
  int                re_cnt = 0;
  int                we_cnt = 0;
  int                both_cnt = 0;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  bubble_sort_engine #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SWAP_W(SWAP_W)
  ) dut (
    .c_clk(clk), .c_rst(rst), .c_go(go), .c_desc(desc),
    .c_busy(busy), .c_done(done), .c_addr(addr), .c_re(re), .c_we(we),
    .c_wdata(wdata), .c_rdata(rdata), .c_out_valid(out_valid),
    .c_out_data(out_data), .c_out_ready(ready), .c_swaps(swaps)
  );

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= load_vec[8*k +: 8];
    end else if (we) begin
      mem[addr] <= wdata;
    end
    if (re) rdata <= mem[addr];
  end

  always @(posedge clk) begin
    if (re) re_cnt <= re_cnt + 1;
    if (we) we_cnt <= we_cnt + 1;
    if (re && we) both_cnt <= both_cnt + 1;
  end

  function automatic logic [63:0] p8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Bubble sort performs exactly one swap per out-of-order pair.
  function automatic int inversions(input logic [63:0] v, input logic dsc);
    int n;
    logic [7:0] x, y;
    n = 0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int b = a + 1; b < DEPTH; b++) begin
        x = v[8*a +: 8];
        y = v[8*b +: 8];
        if (dsc ? (x < y) : (x > y)) n++;
      end
    end
    return n;
  endfunction

  task automatic check_idle_zero(input string name);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy: got %b want 0", name, busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done: got %b want 0", name, done); end
    checks++; if ({re, we} !== 2'b00) begin failures++; $display("FAIL %s re_we: got %b want 00", name, {re, we}); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s out_valid: got %b want 0", name, out_valid); end
    checks++; if (addr !== '0) begin failures++; $display("FAIL %s addr: got %0d want 0", name, addr); end
    checks++; if (wdata !== '0) begin failures++; $display("FAIL %s wdata: got %0d want 0", name, wdata); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL %s out_data: got %0d want 0", name, out_data); end
    checks++; if (swaps !== '0) begin failures++; $display("FAIL %s swaps: got %0d want 0", name, swaps); end
  endtask

  task automatic run_sort(input string name, input logic [63:0] init, input logic [63:0] exp,
                          input logic dsc, input int stall_beat, input bit noise,
                          input int exp_cycles, input int exp_re);
    int cyc, beat, hold, done_cnt, done_cyc, re0, we0, both0, exp_sw;
    bit finished;
    logic [63:0] got;
    exp_sw = inversions(init, dsc);
    ready = 1'b1;
    desc  = dsc;
    @(posedge clk); #1;
    load_vec = init;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    re0 = re_cnt; we0 = we_cnt; both0 = both_cnt;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    if (noise) desc = ~dsc;
    cyc = 1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_go: got %b want 1", name, busy); end
    beat = 0; hold = 0; done_cnt = 0; done_cyc = 0; finished = 0;
    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (noise) begin
        go   = (cyc % 13 == 5);
        desc = ~desc;
      end
      if (done) begin
        go = 1'b0;
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
      end else if (out_valid) begin
        if (beat >= DEPTH) begin
          checks++; failures++;
          $display("FAIL %s extra_beat: got beat %0d want at most %0d", name, beat, DEPTH);
          finished = 1;
        end else if (beat == stall_beat && hold < 5) begin
          ready = 1'b0;
          hold++;
          checks++;
          if (out_data !== exp[8*beat +: 8]) begin
            failures++;
            $display("FAIL %s held_beat%0d: got %0d want %0d", name, beat, out_data, exp[8*beat +: 8]);
          end
        end else begin
          ready = 1'b1;
          checks++;
          if (out_data !== exp[8*beat +: 8]) begin
            failures++;
            $display("FAIL %s beat%0d: got %0d want %0d", name, beat, out_data, exp[8*beat +: 8]);
          end
          beat++;
        end
      end
    end
    go = 1'b0;
    ready = 1'b1;
    checks++; if (!finished) begin failures++; $display("FAIL %s timeout: got no done after %0d cycles want done", name, cyc); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt); end
    checks++; if (beat != DEPTH) begin failures++; $display("FAIL %s beats: got %0d want %0d", name, beat, DEPTH); end
    checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL %s idle_after: got busy,valid=%b want 00", name, {busy, out_valid}); end
    checks++; if (swaps !== SWAP_W'(exp_sw)) begin failures++; $display("FAIL %s swaps: got %0d want %0d", name, swaps, exp_sw); end
    checks++; if (we_cnt - we0 != 2 * exp_sw) begin failures++; $display("FAIL %s writes: got %0d want %0d", name, we_cnt - we0, 2 * exp_sw); end
    checks++; if (both_cnt != both0) begin failures++; $display("FAIL %s re_and_we: got %0d cycles want 0", name, both_cnt - both0); end
    for (int k = 0; k < DEPTH; k++) got[8*k +: 8] = mem[k];
    checks++; if (got !== exp) begin failures++; $display("FAIL %s ram: got %h want %h", name, got, exp); end
    if (exp_cycles > 0) begin
      checks++; if (done_cyc != exp_cycles) begin failures++; $display("FAIL %s latency: got %0d want %0d", name, done_cyc, exp_cycles); end
    end
    if (exp_re >= 0) begin
      checks++; if (re_cnt - re0 != exp_re) begin failures++; $display("FAIL %s reads: got %0d want %0d", name, re_cnt - re0, exp_re); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    run_sort("asc", p8(5, 3, 8, 1, 9, 2, 7, 4), p8(1, 2, 3, 4, 5, 7, 8, 9), 1'b0, -1, 1'b0, -1, -1);
  endtask

  task automatic test_descending();
    run_sort("desc", p8(5, 3, 8, 1, 9, 2, 7, 4), p8(9, 8, 7, 5, 4, 3, 2, 1), 1'b1, -1, 1'b0, -1, -1);
  endtask

  // One pass of 7 five-cycle compares, PASS_INIT/PASS_END, then 8 three-cycle beats.
  task automatic test_presorted();
    run_sort("presorted", p8(1, 2, 3, 4, 5, 6, 7, 8), p8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, -1, 1'b0, 62, 22);
  endtask

  task automatic test_duplicates();
    run_sort("dups", p8(4, 4, 2, 2, 4, 2, 4, 2), p8(2, 2, 2, 2, 4, 4, 4, 4), 1'b0, -1, 1'b0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_sort("stall", p8(5, 3, 8, 1, 9, 2, 7, 4), p8(1, 2, 3, 4, 5, 7, 8, 9), 1'b0, 3, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    int stray_done;
    @(posedge clk); #1;
    load_vec = p8(5, 3, 8, 1, 9, 2, 7, 4);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    desc = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (swaps === '0 || busy !== 1'b1) begin failures++; $display("FAIL midrun_progress: got busy=%b swaps=%0d want busy=1 swaps>0", busy, swaps); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("midrun_reset");
    stray_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) stray_done++;
    end
    checks++; if (stray_done != 0) begin failures++; $display("FAIL after_reset_quiet: got %0d active cycles want 0", stray_done); end
    run_sort("rerun_noise", p8(6, 1, 8, 3, 2, 7, 5, 4), p8(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, -1, 1'b1, -1, -1);
    run_sort("back_to_back", p8(2, 9, 4, 9, 1, 6, 0, 3), p8(9, 9, 6, 4, 3, 2, 1, 0), 1'b1, -1, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_presorted();
    test_duplicates();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
